mig_cmd_seq: RTL and testbench

MIG_CMD_SEQ -- requirements
Module: mig_cmd_seq

---
 rtl/mig_seq_pkg.sv | 20 ++
 rtl/mig_cmd_seq_if.sv | 39 +++
 rtl/mig_rd_ocnt.sv | 45 ++++
 rtl/mig_cmd_seq.sv | 151 +++++++++++++++
 tb/tb_mig_cmd_seq.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mig_seq_pkg.sv
// rtl/mig_seq_pkg.sv - shared types and constants for the MIG command sequencer
//
// Holds the MIG app_cmd encodings, the sequencer FSM state type and the
// default widths used by the interface, the counter and the top level.
package mig_seq_pkg;

    localparam int APP_AW_DEF = 28;
    localparam int DW_DEF     = 128;
    localparam int MAX_RD_DEF = 4;
    localparam int RD_CNT_W   = 4;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_e;

endpackage

// File: rtl/mig_cmd_seq_if.sv
// rtl/mig_cmd_seq_if.sv - MIG user (app_*) interface bundle
//
// master : sequencer side, drives command and write data, receives ready
//          and read return.
// slave  : MIG side, the mirror image.
interface mig_cmd_seq_if
    import mig_seq_pkg::*;
#(
    parameter int APP_AW = APP_AW_DEF,
    parameter int DW     = DW_DEF
);
    logic [APP_AW-1:0] app_addr;
    logic [2:0]        app_cmd;
    logic              app_en;
    logic              app_rdy;
    logic [DW-1:0]     app_wdf_data;
    logic [DW/8-1:0]   app_wdf_mask;
    logic              app_wdf_wren;
    logic              app_wdf_end;
    logic              app_wdf_rdy;
    logic [DW-1:0]     app_rd_data;
    logic              app_rd_data_valid;
    logic              app_rd_data_end;

    modport master (
        output app_addr, app_cmd, app_en,
        output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy,
        input  app_rd_data, app_rd_data_valid, app_rd_data_end
    );

    modport slave (
        input  app_addr, app_cmd, app_en,
        input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy,
        output app_rd_data, app_rd_data_valid, app_rd_data_end
    );

endinterface

// File: rtl/mig_rd_ocnt.sv
// rtl/mig_rd_ocnt.sv - outstanding MIG read counter
//
// Ports:
//   mclk, mrst_n : clock, asynchronous active-low reset
//   inc          : a read command was accepted this cycle
//   dec          : the last beat of a read return arrived this cycle
//   count        : reads issued but not yet returned
module mig_rd_ocnt #(
    parameter int MAX = 4,
    parameter int W   = 4
) (
    input  logic         mclk,
    input  logic         mrst_n,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Simultaneous inc and dec cancel; the saturation guards keep a
    // misbehaving MIG from wrapping the count.
    always_comb begin
        count_d = count_q;
        if (inc && !dec && (count_q < MAX_C)) begin
            count_d = count_q + W'(1);
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/mig_cmd_seq.sv
// rtl/mig_cmd_seq.sv - pops line requests and issues them as MIG app commands
//
// Ports:
//   mclk, mrst_n        : clock, asynchronous active-low reset
//   init_calib_complete : MIG calibration done; gates new requests only
//   rqempty, qraddr,    : request queue head (empty flag, byte address,
//   rd_bwt, rnext       :   1=read/0=write) and its one-cycle pop pulse
//   wbuf_data/mask,     : write data for a head write, and its pop pulse
//   wbuf_pop            :   issued in the MIG data accept cycle
//   app                 : MIG app_* bundle (master side)
//   rdat, rdat_valid    : read return, registered one cycle after MIG
//   busy                : a command in flight or reads still outstanding
module mig_cmd_seq
    import mig_seq_pkg::*;
#(
    parameter int APP_AW = APP_AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int MAX_RD = MAX_RD_DEF
) (
    input  logic            mclk,
    input  logic            mrst_n,
    input  logic            init_calib_complete,
    input  logic            rqempty,
    input  logic [31:0]     qraddr,
    input  logic            rd_bwt,
    output logic            rnext,
    input  logic [DW-1:0]   wbuf_data,
    input  logic [DW/8-1:0] wbuf_mask,
    output logic            wbuf_pop,
    mig_cmd_seq_if.master   app,
    output logic [DW-1:0]   rdat,
    output logic            rdat_valid,
    output logic            busy
);

    localparam logic [RD_CNT_W-1:0] MAX_RD_C = RD_CNT_W'(MAX_RD);

    seq_state_e        state_q,    state_d;
    logic              rnext_q,    rnext_d;
    logic              app_en_q,   app_en_d;
    logic              wren_q,     wren_d;
    logic [APP_AW-1:0] addr_q,     addr_d;
    logic [2:0]        cmd_q,      cmd_d;
    logic [DW-1:0]     wdata_q,    wdata_d;
    logic [DW/8-1:0]   wmask_q,    wmask_d;
    logic [DW-1:0]     rdat_q;
    logic              rdat_valid_q;

    logic [RD_CNT_W-1:0] rd_out;
    logic                start;
    logic                rd_cmd_acc;
    logic                rd_ret;

    // Byte-address bits below the 16-byte line and above the MIG address
    // range are not part of the command.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{qraddr[3:0], qraddr[31:APP_AW+1]};

    assign rd_cmd_acc = app_en_q & app.app_rdy & (cmd_q == CMD_RD);
    assign rd_ret     = app.app_rd_data_valid & app.app_rd_data_end;

    mig_rd_ocnt #(
        .MAX (MAX_RD),
        .W   (RD_CNT_W)
    ) u_ocnt (
        .mclk   (mclk),
        .mrst_n (mrst_n),
        .inc    (rd_cmd_acc),
        .dec    (rd_ret),
        .count  (rd_out)
    );

    // Command and write data handshakes run independently; each valid
    // drops the cycle after its own accept and the FSM leaves ISSUE once
    // both are down. The pop is registered, so the queue head updates one
    // cycle after the start decision; the IDLE cycle that follows ISSUE
    // therefore always sees the post-pop head.
    always_comb begin
        state_d  = state_q;
        rnext_d  = 1'b0;
        app_en_d = app_en_q & ~app.app_rdy;
        wren_d   = wren_q & ~app.app_wdf_rdy;
        addr_d   = addr_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        wmask_d  = wmask_q;
        start    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                start = init_calib_complete & ~rqempty &
                        (rd_bwt ? (rd_out < MAX_RD_C) : 1'b1);
                if (start) begin
                    state_d  = ST_ISSUE;
                    rnext_d  = 1'b1;
                    app_en_d = 1'b1;
                    wren_d   = ~rd_bwt;
                    addr_d   = {qraddr[APP_AW:4], 3'b000};
                    cmd_d    = rd_bwt ? CMD_RD : CMD_WR;
                    wdata_d  = wbuf_data;
                    wmask_d  = wbuf_mask;
                end
            end
            ST_ISSUE: begin
                if (!app_en_d && !wren_d) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_q      <= ST_IDLE;
            rnext_q      <= 1'b0;
            app_en_q     <= 1'b0;
            wren_q       <= 1'b0;
            addr_q       <= '0;
            cmd_q        <= CMD_WR;
            wdata_q      <= '0;
            wmask_q      <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnext_q      <= rnext_d;
            app_en_q     <= app_en_d;
            wren_q       <= wren_d;
            addr_q       <= addr_d;
            cmd_q        <= cmd_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            rdat_q       <= app.app_rd_data;
            rdat_valid_q <= app.app_rd_data_valid;
        end
    end

    assign rnext            = rnext_q;
    assign wbuf_pop         = wren_q & app.app_wdf_rdy;
    assign app.app_addr     = addr_q;
    assign app.app_cmd      = cmd_q;
    assign app.app_en       = app_en_q;
    assign app.app_wdf_data = wdata_q;
    assign app.app_wdf_mask = wmask_q;
    assign app.app_wdf_wren = wren_q;
    assign app.app_wdf_end  = wren_q;
    assign rdat             = rdat_q;
    assign rdat_valid       = rdat_valid_q;
    assign busy             = (state_q != ST_IDLE) | (rd_out != '0);

endmodule

// File: tb/tb_mig_cmd_seq.sv
// tb/tb_mig_cmd_seq.sv - self-checking bench for mig_cmd_seq
module tb_mig_cmd_seq;

    localparam int APP_AW = 28;
    localparam int DW     = 128;
    localparam int MAX_RD = 4;

    logic            mclk = 1'b0;
    logic            mrst_n = 1'b0;
    logic            init_calib_complete = 1'b1;
    logic            rqempty;
    logic [31:0]     qraddr;
    logic            rd_bwt;
    logic            rnext;
    logic [DW-1:0]   wbuf_data;
    logic [DW/8-1:0] wbuf_mask;
    logic            wbuf_pop;
    logic [DW-1:0]   rdat;
    logic            rdat_valid;
    logic            busy;

    mig_cmd_seq_if #(.APP_AW(APP_AW), .DW(DW)) app ();

    mig_cmd_seq #(.APP_AW(APP_AW), .DW(DW), .MAX_RD(MAX_RD)) dut (
        .mclk                (mclk),
        .mrst_n              (mrst_n),
        .init_calib_complete (init_calib_complete),
        .rqempty             (rqempty),
        .qraddr              (qraddr),
        .rd_bwt              (rd_bwt),
        .rnext               (rnext),
        .wbuf_data           (wbuf_data),
        .wbuf_mask           (wbuf_mask),
        .wbuf_pop            (wbuf_pop),
        .app                 (app),
        .rdat                (rdat),
        .rdat_valid          (rdat_valid),
        .busy                (busy)
    );

    always #5 mclk = ~mclk;

    // Request queue model: the bench pushes, the DUT pops with rnext.
    logic [31:0]     q_addr [64];
    logic            q_rd   [64];
    logic [DW-1:0]   q_data [64];
    logic [DW/8-1:0] q_mask [64];
    logic [5:0]      wptr = '0;
    logic [5:0]      rptr = '0;

    always @(posedge mclk) begin
        if (rnext) rptr <= rptr + 6'd1;
    end

    assign rqempty   = (rptr == wptr);
    assign qraddr    = q_addr[rptr];
    assign rd_bwt    = q_rd[rptr];
    assign wbuf_data = q_data[rptr];
    assign wbuf_mask = q_mask[rptr];

    int n_chk  = 0;
    int n_fail = 0;
    int g_en   = 0;
    int g_rn   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic rd, input logic [31:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] m);
        q_addr[wptr] = a;
        q_rd[wptr]   = rd;
        q_data[wptr] = d;
        q_mask[wptr] = m;
        wptr = wptr + 6'd1;
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
        if (app.app_en) g_en++;
        if (rnext) g_rn++;
    endtask

    typedef struct {
        logic              rd;
        logic [31:0]       addr;
        int                rlo;
        int                wlo;
        logic [APP_AW-1:0] exp_addr;
        logic [2:0]        exp_cmd;
        int                exp_en;
        int                exp_wren;
        logic [DW-1:0]     data;
        logic [DW/8-1:0]   mask;
    } vec_t;

    vec_t vecs [6];

    task automatic run_vec(input int idx, input vec_t v);
        int en, wr, rn, pop;
        logic bad;
        en = 0; wr = 0; rn = 0; pop = 0; bad = 1'b0;
        app.app_rdy = 1'b0;
        app.app_wdf_rdy = 1'b0;
        push(v.rd, v.addr, v.data, v.mask);
        for (int c = 0; c < 12; c++) begin
            @(posedge mclk);
            #1;
            if (rnext) rn++;
            if (app.app_en) begin
                en++;
                if (app.app_addr !== v.exp_addr || app.app_cmd !== v.exp_cmd) bad = 1'b1;
                app.app_rdy = (en > v.rlo);
            end else begin
                app.app_rdy = 1'b0;
            end
            if (app.app_wdf_wren) begin
                wr++;
                if (app.app_wdf_data !== v.data || app.app_wdf_mask !== v.mask ||
                    app.app_wdf_end !== 1'b1) bad = 1'b1;
                app.app_wdf_rdy = (wr > v.wlo);
            end else begin
                app.app_wdf_rdy = 1'b0;
            end
            #1;
            if (wbuf_pop) pop++;
        end
        chk($sformatf("v%0d app_en cycles", idx), DW'(en), DW'(v.exp_en));
        chk($sformatf("v%0d wdf_wren cycles", idx), DW'(wr), DW'(v.exp_wren));
        chk($sformatf("v%0d rnext pulses", idx), DW'(rn), DW'(1));
        chk($sformatf("v%0d wbuf_pop pulses", idx), DW'(pop), DW'(v.rd ? 0 : 1));
        chk($sformatf("v%0d addr/cmd/data stable", idx), DW'(bad), DW'(0));
        chk($sformatf("v%0d busy after issue", idx), DW'(busy), DW'(v.rd));
        if (v.rd) begin
            app.app_rd_data = v.data;
            app.app_rd_data_valid = 1'b1;
            app.app_rd_data_end = 1'b1;
            tick();
            app.app_rd_data_valid = 1'b0;
            app.app_rd_data_end = 1'b0;
            chk($sformatf("v%0d rdat_valid", idx), DW'(rdat_valid), DW'(1));
            chk($sformatf("v%0d rdat", idx), rdat, v.data);
            tick();
            chk($sformatf("v%0d busy after return", idx), DW'(busy), DW'(0));
        end
    endtask

    task automatic ret_pulse(input logic [DW-1:0] d);
        app.app_rd_data = d;
        app.app_rd_data_valid = 1'b1;
        app.app_rd_data_end = 1'b1;
        tick();
        app.app_rd_data_valid = 1'b0;
        app.app_rd_data_end = 1'b0;
    endtask

    initial begin
        app.app_rdy = 1'b0;
        app.app_wdf_rdy = 1'b0;
        app.app_rd_data = '0;
        app.app_rd_data_valid = 1'b0;
        app.app_rd_data_end = 1'b0;

        // rd, addr, rlo, wlo, app_addr = {addr[28:4],3'b000}, cmd, en cycles, wren cycles, data, mask
        vecs[0] = '{1'b0, 32'h0000_1230, 0, 0, 28'h000_0918, 3'b000, 1, 1, {4{32'hA500_0000}}, 16'h0F0F};
        vecs[1] = '{1'b0, 32'h0000_4560, 3, 0, 28'h000_22B0, 3'b000, 4, 1, {4{32'hA500_0001}}, 16'h0000};
        vecs[2] = '{1'b0, 32'h1000_00F0, 0, 2, 28'h800_0078, 3'b000, 1, 3, {4{32'hA500_0002}}, 16'hFFFF};
        vecs[3] = '{1'b1, 32'h0000_0AB0, 1, 0, 28'h000_0558, 3'b001, 2, 0, {4{32'h5A00_0003}}, 16'h1234};
        vecs[4] = '{1'b1, 32'h1FFF_FFF0, 0, 0, 28'hFFF_FFF8, 3'b001, 1, 0, {4{32'h5A00_0004}}, 16'h0001};
        vecs[5] = '{1'b0, 32'hFFFF_FFFF, 2, 4, 28'hFFF_FFF8, 3'b000, 3, 5, {4{32'hA500_0005}}, 16'h8001};

        // Reset state
        repeat (3) tick();
        chk("reset rnext", DW'(rnext), DW'(0));
        chk("reset app_en", DW'(app.app_en), DW'(0));
        chk("reset app_wdf_wren", DW'(app.app_wdf_wren), DW'(0));
        chk("reset busy", DW'(busy), DW'(0));
        chk("reset rdat_valid", DW'(rdat_valid), DW'(0));
        chk("reset app_addr", DW'(app.app_addr), DW'(0));
        mrst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // MAX_RD limits outstanding reads; one return frees a slot.
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b1;
        for (int i = 0; i < 6; i++) push(1'b1, 32'h0000_2000 + 32'(i * 16), '0, '0);
        g_en = 0; g_rn = 0;
        repeat (30) tick();
        chk("maxrd accepts", DW'(g_en), DW'(4));
        chk("maxrd rnext", DW'(g_rn), DW'(4));
        chk("maxrd busy", DW'(busy), DW'(1));
        chk("maxrd rd_out", DW'(dut.rd_out), DW'(4));
        ret_pulse({4{32'h0000_C001}});
        repeat (5) tick();
        chk("maxrd fifth issued", DW'(g_en), DW'(5));
        for (int i = 0; i < 5; i++) begin
            ret_pulse({4{32'h0000_D000}});
            repeat (4) tick();
        end
        chk("maxrd sixth issued", DW'(g_en), DW'(6));
        chk("maxrd drained busy", DW'(busy), DW'(0));

        // Read command accept in the same cycle as a read return.
        app.app_rdy = 1'b0;
        push(1'b1, 32'h0000_3000, '0, '0);
        g_en = 0;
        for (int c = 0; c < 5 && g_en == 0; c++) tick();
        app.app_rdy = 1'b1;
        tick();
        app.app_rdy = 1'b0;
        push(1'b1, 32'h0000_3010, '0, '0);
        g_en = 0;
        for (int c = 0; c < 6 && g_en == 0; c++) tick();
        chk("coinc second read issued", DW'(g_en), DW'(1));
        app.app_rdy = 1'b1;
        app.app_rd_data = {4{32'hBEEF_0001}};
        app.app_rd_data_valid = 1'b1;
        app.app_rd_data_end = 1'b1;
        tick();
        app.app_rdy = 1'b0;
        app.app_rd_data_valid = 1'b0;
        app.app_rd_data_end = 1'b0;
        chk("coinc rdat_valid", DW'(rdat_valid), DW'(1));
        chk("coinc rdat", rdat, {4{32'hBEEF_0001}});
        chk("coinc rd_out", DW'(dut.rd_out), DW'(1));
        tick();
        chk("coinc rdat_valid one cycle", DW'(rdat_valid), DW'(0));
        chk("coinc busy outstanding", DW'(busy), DW'(1));
        ret_pulse({4{32'h0000_0002}});
        tick();
        chk("coinc busy drained", DW'(busy), DW'(0));

        // Calibration gate
        init_calib_complete = 1'b0;
        app.app_rdy = 1'b1;
        app.app_wdf_rdy = 1'b1;
        push(1'b0, 32'h0000_4000, {4{32'h1111_2222}}, 16'h00FF);
        g_rn = 0;
        repeat (20) tick();
        chk("calib low rnext", DW'(g_rn), DW'(0));
        chk("calib low busy", DW'(busy), DW'(0));
        init_calib_complete = 1'b1;
        tick();
        chk("calib rise rnext", DW'(rnext), DW'(1));
        repeat (3) tick();
        chk("calib write done", DW'(busy), DW'(0));

        // Reset in the middle of ISSUE
        app.app_rdy = 1'b0;
        app.app_wdf_rdy = 1'b1;
        push(1'b0, 32'h0000_5000, {4{32'h3333_4444}}, 16'h0000);
        repeat (3) tick();
        chk("mid-issue app_en held", DW'(app.app_en), DW'(1));
        mrst_n = 1'b0;
        #1;
        chk("rst app_en", DW'(app.app_en), DW'(0));
        chk("rst rnext", DW'(rnext), DW'(0));
        chk("rst busy", DW'(busy), DW'(0));
        chk("rst app_addr", DW'(app.app_addr), DW'(0));
        repeat (2) tick();
        mrst_n = 1'b1;
        app.app_rdy = 1'b1;
        push(1'b0, 32'h0000_5010, {4{32'h5555_6666}}, 16'h0000);
        g_en = 0; g_rn = 0;
        repeat (6) tick();
        chk("post-reset app_en", DW'(g_en), DW'(1));
        chk("post-reset rnext", DW'(g_rn), DW'(1));
        chk("post-reset busy", DW'(busy), DW'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
